// File: rtl/fetch_queue.sv
// Prefetching instruction fetch stage: issues imem requests ahead of decode,
// buffers returned instructions with their PCs and squashes in-flight work on redirect.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            valid_d,
    input  logic            ready_d,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0]  resp_pc, resp_pc_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] inflight, inflight_nxt;
    logic [CNT_W-1:0] discard, discard_nxt;
    logic [CNT_W-1:0] count_after_pop;
    logic             valid_nxt;
    logic [XLEN-1:0]  pc_nxt, instr_nxt;

    logic [XLEN-1:0]  q_pc    [DEPTH];
    logic [XLEN-1:0]  q_instr [DEPTH];

    logic credit_ok, accept, rsp, drop, push, pop;

    // Credit rule: never request more than the queue can absorb.
    assign credit_ok = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);
    assign imem_req  = ~reset & ~redirect & credit_ok;
    assign imem_addr = fetch_pc;

    // A response with nothing outstanding is stray and leaves state untouched.
    assign accept = imem_req & imem_gnt;
    assign rsp    = imem_rvalid & (inflight != '0);
    assign drop   = rsp & (discard != '0);
    assign push   = rsp & (discard == '0) & ~redirect;
    assign pop    = valid_d & ready_d & ~redirect;

    assign count_after_pop = count - CNT_W'(pop);

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        resp_pc_nxt  = resp_pc;
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = count;
        discard_nxt  = discard;
        inflight_nxt = inflight + CNT_W'(accept) - CNT_W'(rsp);
        valid_nxt    = valid_d;
        pc_nxt       = pc_d;
        instr_nxt    = instr_d;

        if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc_nxt = redirect_pc;
            resp_pc_nxt  = redirect_pc;
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
            discard_nxt  = inflight - CNT_W'(rsp);
            valid_nxt    = 1'b0;
        end else begin
            if (accept) begin
                fetch_pc_nxt = fetch_pc + XLEN'(4);
            end
            if (drop) begin
                discard_nxt = discard - CNT_W'(1);
            end
            if (push) begin
                wr_ptr_nxt  = wr_ptr + PTR_W'(1);
                resp_pc_nxt = resp_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            count_nxt = count_after_pop + CNT_W'(push);
            valid_nxt = (count_nxt != '0);

            // Next head is either the entry being written into an empty queue or stored data.
            if (push && (count_after_pop == '0)) begin
                pc_nxt    = resp_pc;
                instr_nxt = imem_rdata;
            end else if (count_nxt != '0) begin
                pc_nxt    = q_pc[rd_ptr_nxt];
                instr_nxt = q_instr[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            inflight  <= '0;
            discard   <= '0;
            valid_d   <= 1'b0;
            pc_d      <= '0;
            instr_d   <= '0;
            pcplus4_d <= XLEN'(4);
        end else begin
            fetch_pc  <= fetch_pc_nxt;
            resp_pc   <= resp_pc_nxt;
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            count     <= count_nxt;
            inflight  <= inflight_nxt;
            discard   <= discard_nxt;
            valid_d   <= valid_nxt;
            pc_d      <= pc_nxt;
            instr_d   <= instr_nxt;
            pcplus4_d <= pc_nxt + XLEN'(4);
        end
    end

    // Queue storage needs no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order variable-latency memory model,
// expected {pc, instr} stream queued by stimulus and compared by a monitor.
module tb_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            valid_d;
    logic            ready_d;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pcplus4_d;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .valid_d(valid_d), .ready_d(ready_d), .instr_d(instr_d),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    req_t pend[$];
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    int cyc      = 0;
    int lat      = 1;
    int p0;

    logic        rst_q, rdy_q, redir_q, gnt_en, inject;
    logic [31:0] rtgt_q;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_stream(input logic [31:0] base, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = base + 32'(4 * i);
            e.instr = mem_word(e.pc);
            sb.push_back(e);
        end
    endtask

    // One clock: drive inputs at negedge, then the memory model reacts 1ns later.
    task automatic tick();
        @(negedge clk);
        cyc++;
        reset       = rst_q;
        ready_d     = rdy_q;
        redirect    = redir_q;
        redirect_pc = rtgt_q;
        redir_q     = 1'b0;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            pend.delete(0);
        end else if (inject) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        inject   = 1'b0;
        imem_gnt = gnt_en;
        if (imem_req && imem_gnt) begin
            req_t r;
            r.addr = imem_addr;
            r.due  = cyc + lat;
            pend.push_back(r);
        end
    endtask

    // Monitor: every accepted head entry must match the next expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && !redirect && valid_d && ready_d) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pop: got pc %h expected no output", pc_d);
                end else begin
                    e = sb.pop_front();
                    check("pc_d", pc_d, e.pc);
                    check("instr_d", instr_d, e.instr);
                    check("pcplus4_d", pcplus4_d, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ready_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        rst_q = 1'b1; rdy_q = 1'b1; redir_q = 1'b0; rtgt_q = '0; gnt_en = 1'b1; inject = 1'b0;

        repeat (3) tick();
        check("rst_valid_d", 32'(valid_d), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_instr_d", instr_d, 32'h0);
        check("rst_pcplus4_d", pcplus4_d, 32'h4);

        // Straight-line, 1-cycle memory.
        expect_stream(32'h0, 64);
        rst_q = 1'b0;
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check("valid_t1", 32'(valid_d), 32'd0);
        tick();
        check("valid_t2", 32'(valid_d), 32'd1);
        check("pc_t2", pc_d, 32'h0);
        p0 = n_pops;
        repeat (10) tick();
        check("sustained_pops", 32'(n_pops - p0), 32'd10);

        // Backpressure fills the queue and stops requests.
        rdy_q = 1'b0;
        repeat (10) tick();
        check("full_req_off", 32'(imem_req), 32'd0);
        check("full_valid", 32'(valid_d), 32'd1);
        rdy_q = 1'b1;
        p0 = n_pops;
        repeat (8) tick();
        check("release_pops", 32'(n_pops - p0), 32'd7);

        // Redirect coincident with a response and a pop, 1-cycle memory.
        redir_q = 1'b1; rtgt_q = 32'h180;
        tick();
        expect_stream(32'h180, 64);
        check("redir_req_off", 32'(imem_req), 32'd0);
        tick();
        check("redir_req_t1", 32'(imem_req), 32'd1);
        check("redir_addr_t1", imem_addr, 32'h180);
        check("redir_valid_t1", 32'(valid_d), 32'd0);
        tick();
        check("redir_valid_t2", 32'(valid_d), 32'd0);
        tick();
        check("redir_valid_t3", 32'(valid_d), 32'd1);
        check("redir_pc_t3", pc_d, 32'h180);

        // Redirect with several responses in flight, 3-cycle memory.
        lat = 3;
        repeat (12) tick();
        redir_q = 1'b1; rtgt_q = 32'h100;
        tick();
        expect_stream(32'h100, 64);
        check("r100_req_off", 32'(imem_req), 32'd0);
        tick();
        check("r100_addr", imem_addr, 32'h100);
        check("r100_req", 32'(imem_req), 32'd1);
        repeat (3) tick();
        check("r100_valid_t4", 32'(valid_d), 32'd0);
        tick();
        check("r100_valid_t5", 32'(valid_d), 32'd1);
        check("r100_pc_t5", pc_d, 32'h100);
        repeat (10) tick();

        // Back-to-back redirects: only the second target survives.
        redir_q = 1'b1; rtgt_q = 32'h200;
        tick();
        expect_stream(32'h200, 64);
        redir_q = 1'b1; rtgt_q = 32'h300;
        tick();
        expect_stream(32'h300, 64);
        check("b2b_req_off", 32'(imem_req), 32'd0);
        p0 = n_pops;
        repeat (20) tick();
        check("b2b_progress", 32'(n_pops - p0 >= 5), 32'd1);

        // Asynchronous reset mid-stream; stale and stray responses must be ignored.
        #3;
        rst_q = 1'b1; reset = 1'b1; gnt_en = 1'b0;
        #1;
        sb.delete();
        check("arst_valid_d", 32'(valid_d), 32'd0);
        check("arst_imem_req", 32'(imem_req), 32'd0);
        check("arst_pc_d", pc_d, 32'h0);
        check("arst_instr_d", instr_d, 32'h0);
        check("arst_pcplus4_d", pcplus4_d, 32'h4);
        repeat (2) tick();
        rst_q = 1'b0;
        repeat (4) tick();
        inject = 1'b1;
        tick();
        tick();
        check("stray_valid", 32'(valid_d), 32'd0);
        check("stray_req", 32'(imem_req), 32'd1);
        check("stray_addr", imem_addr, 32'h0);
        gnt_en = 1'b1; lat = 1;
        expect_stream(32'h0, 64);
        tick();
        tick();
        tick();
        check("restart_valid", 32'(valid_d), 32'd1);
        check("restart_pc", pc_d, 32'h0);
        p0 = n_pops;
        repeat (10) tick();
        check("restart_pops", 32'(n_pops - p0), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
